pipe_adder: RTL
===============

# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. The carry chain is split into STAGES equal chunks. Each pipeline stage resolves one chunk and registers its carry into the next stage. This gives one result per cycle at a fixed latency of STAGES cycles. It is the wide-datapath arithmetic building block for the team's datapaths and replaces fixed-width combinational ripple adders where timing closure or flow control is needed.

## Interface
- WIDTH, default 32: operand and result width in bits; must be at least 1.
- STAGES, default 4: number of pipeline stages, equal to the latency; must be at least 1 and must divide WIDTH (elaboration error otherwise). Chunk width C = WIDTH/STAGES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b (computed as a+~b+1; cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Transfer on the input occurs when in_valid and in_ready are both 1 at a rising edge. Transfer on the output occurs when out_valid and out_ready are both 1.
- Upstream holds a, b, cin and sub stable while in_valid=1 and in_ready=0. The block makes no assumption about these inputs when in_valid=0.
- Stage 1 is combinational into register S1. It inverts b if sub=1 and takes the carry-in from sub ? 1 : cin. It adds chunk 0, bits [C-1:0], and registers:
  - the chunk-0 sum bits,
  - the chunk-0 carry,
  - the remaining a bits and the remaining (possibly inverted) b bits,
  - a valid bit.
- Stage k (2..STAGES) adds chunk k-1 using the carry registered by stage k-1. It appends these sum bits to the completed low bits and passes the remaining operand bits along.
- The final stage (S_STAGES) also registers cout and ovf. ovf uses the carry into bit WIDTH-1, taken inside the final chunk.
- sum, cout, ovf and out_valid are driven directly from the S_STAGES registers. There is no combinational path from a, b, cin or sub to the outputs.
- Flow control:
  - Each stage advances when it is empty or when its successor advances in the same cycle.
  - The last stage advances when out_ready=1 or when it is empty.
  - Bubbles collapse.
  - in_ready = !S1.valid || S1 advances. This is combinational from out_ready through the valid chain. That path is acceptable for STAGES ≤ 8.
- Capacity is STAGES results. Ordering is strictly FIFO. There is no loss and no duplication.
- A stalled stage holds all of its registers unchanged, so outputs stay stable while out_valid=1 and out_ready=0.
- STAGES=1 degenerates to a single registered adder with a handshake. STAGES=WIDTH gives 1-bit chunks.

## Timing
- Reset (rst_n=0, asynchronous): every stage valid, sum, cout, ovf and out_valid clear to 0 immediately, with no clock needed. in_ready=1 while the pipeline is empty, including during reset.
- Latency: an operand pair accepted at edge t appears with out_valid=1 after edge t+STAGES-1. Example: STAGES=1 gives its result one cycle after acceptance. This assumes no downstream stall.
- Throughput: one result per cycle with in_valid=1 and out_ready=1 held continuously.
- Under stall (out_ready=0), the block accepts until all STAGES registers hold valid data, then deasserts in_ready. A single out_ready=1 cycle frees one slot, and in_ready reasserts in that same cycle.
- Simultaneous accept and drain on a full pipeline is allowed: occupancy is unchanged.
- Reset asserted mid-operation: all in-flight results are discarded. No pre-reset result ever appears after rst_n deasserts. The first result after reset is the first operand pair accepted after reset.
- Widths are exact modulo 2^WIDTH. There is no saturation.

## Test plan
All scenarios use WIDTH=8, STAGES=4 (C=2) unless noted.
- Reset: rst_n=0 with the clock stopped -> out_valid=0, sum=0x00, cout=0, ovf=0, in_ready=1 immediately. The same values hold after release until the first transfer.
- Full ripple: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance. With cin: a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0.
- Overflow/subtract:
  - a=0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
  - a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0 (cin ignored).
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Streaming: 64 random back-to-back transactions with mixed sub and out_ready=1 -> one result per cycle, in order, bit-exact against a reference model.
- Backpressure: out_ready=0 for 8 cycles with in_valid=1 continuously -> exactly 4 accepted, then in_ready=0 and outputs stable. On release, the 4 results drain in order, followed by the stream, with no gaps beyond the handshake and no loss or duplication.
- Mid-stream reset: assert rst_n with 3 results in flight -> out_valid=0 at once. After release, the next result is for the first post-reset operands. Repeat with STAGES=1 and with STAGES=8.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined two's-complement adder/subtractor with valid/ready on both sides.
//
// The carry chain is cut into STAGES chunks of C = WIDTH/STAGES bits. Stage k adds chunk k
// using the carry registered by stage k-1. It appends its bits to the completed low-order
// sum and forwards the operand bits that are still unconsumed.
//
// Parameters:
//   WIDTH   operand/result width (>= 1)
//   STAGES  pipeline depth = latency = capacity (>= 1, must divide WIDTH)
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   upstream handshake
//   a, b, cin, sub       operands; sub=1 computes a-b (cin ignored), else a+b+cin
//   out_valid, out_ready downstream handshake
//   sum, cout, ovf       result, carry out of MSB (1 = no borrow on subtract), signed overflow
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned C = (STAGES == 0) ? 1 : WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be >= 1 and STAGES must be >= 1 and divide WIDTH");
  end

  // Subtraction is a + ~b + 1: the "+1" rides in as the chunk-0 carry.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Bits of each operand still to be added on entry to this stage (current chunk + above).
    localparam int unsigned Rin = WIDTH - k * C;
    localparam int unsigned Hi  = (k + 1) * C;

    logic           up_vld;
    logic [Rin-1:0] a_in;
    logic [Rin-1:0] b_in;
    logic           ci;
    logic [C:0]     add;
    logic [Hi-1:0]  sum_d;
    logic           adv;

    logic           vld_q;
    logic [Hi-1:0]  sum_q;
    logic           cy_q;

    if (k == 0) begin : g_first
      assign up_vld = in_valid;
      assign a_in   = a;
      assign b_in   = b_eff;
      assign ci     = cin_eff;
      assign sum_d  = add[C-1:0];
    end else begin : g_next
      assign up_vld = g_st[k-1].vld_q;
      assign a_in   = g_st[k-1].g_mid.a_rem_q;
      assign b_in   = g_st[k-1].g_mid.b_rem_q;
      assign ci     = g_st[k-1].cy_q;
      assign sum_d  = {add[C-1:0], g_st[k-1].sum_q};
    end

    assign add = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, ci};

    // A stage takes new contents when it is empty or its contents move on this cycle.
    if (k == STAGES - 1) begin : g_adv_last
      assign adv = !vld_q || out_ready;
    end else begin : g_adv_mid
      assign adv = !vld_q || g_st[k+1].adv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else if (adv) begin
        vld_q <= up_vld;
        // Data only moves with a valid token so a drained stage keeps its last result.
        if (up_vld) begin
          sum_q <= sum_d;
          cy_q  <= add[C];
        end
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [Rin-C-1:0] a_rem_q;
      logic [Rin-C-1:0] b_rem_q;

      // Pure datapath: meaningless unless vld_q is set, so no reset needed.
      always_ff @(posedge clk) begin
        if (adv && up_vld) begin
          a_rem_q <= a_in[Rin-1:C];
          b_rem_q <= b_in[Rin-1:C];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Carry into the MSB recovered from the MSB sum bit: c_in = a ^ b ^ s.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && up_vld) begin
          ovf_q <= add[C] ^ (a_in[C-1] ^ b_in[C-1] ^ add[C-1]);
        end
      end
    end
  end

  assign in_ready  = g_st[0].adv;
  assign out_valid = g_st[STAGES-1].vld_q;
  assign sum       = g_st[STAGES-1].sum_q;
  assign cout      = g_st[STAGES-1].cy_q;
  assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule
